// File: rtl/i2c_calc_pkg.sv
// Shared types and constants for the I2C calculator target: FSM states,
// register map, opcodes and the majority helper used by the bus filter.
package i2c_calc_pkg;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } i2c_state_e;

  localparam logic [4:0] REG_A0     = 5'h00;
  localparam logic [4:0] REG_B0     = 5'h04;
  localparam logic [4:0] REG_CTRL   = 5'h08;
  localparam logic [4:0] REG_STATUS = 5'h09;
  localparam logic [4:0] REG_RES0   = 5'h10;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/i2c_calc_if.sv
// Handshake between the I2C target (master side) and the calculator (slave side).
interface i2c_calc_if;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [1:0]  operation;
  logic        calc_go;
  logic        busy;
  logic [63:0] result;

  modport master (output operand_a, operand_b, operation, calc_go, busy, input result);
  modport slave  (input operand_a, operand_b, operation, calc_go, busy, output result);
endinterface

// File: rtl/i2c_bus_cond.sv
// SCL/SDA conditioning: synchronizer, optional 3-sample majority filter
// (I2C_CALC_GLITCH_FILTER_EN), SCL edge and START/STOP detection.
module i2c_bus_cond
  import i2c_calc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic scl_c, sda_c;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_prev_d = scl_c;
    sda_prev_d = sda_c;
  end

  // Everything resets to the idle-bus level so reset release never looks like START
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

`ifdef I2C_CALC_GLITCH_FILTER_EN
  logic [2:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic       scl_flt_q, scl_flt_d, sda_flt_q, sda_flt_d;

  always_comb begin
    scl_hist_d = {scl_hist_q[1:0], scl_sync_q[SYNC_STAGES-1]};
    sda_hist_d = {sda_hist_q[1:0], sda_sync_q[SYNC_STAGES-1]};
    scl_flt_d  = maj3(scl_hist_q);
    sda_flt_d  = maj3(sda_hist_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_flt_q  <= 1'b1;
      sda_flt_q  <= 1'b1;
    end else begin
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      scl_flt_q  <= scl_flt_d;
      sda_flt_q  <= sda_flt_d;
    end
  end

  assign scl_c = scl_flt_q;
  assign sda_c = sda_flt_q;
`else
  assign scl_c = scl_sync_q[SYNC_STAGES-1];
  assign sda_c = sda_sync_q[SYNC_STAGES-1];
`endif

  assign scl_rise  = scl_c & ~scl_prev_q;
  assign scl_fall  = ~scl_c & scl_prev_q;
  assign sda_s     = sda_c;
  assign start_det = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
  assign stop_det  = scl_c & scl_prev_q & ~sda_prev_q & sda_c;

endmodule

// File: rtl/i2c_calc_target.sv
// I2C target exposing calculator operands/opcode as byte registers and a
// shadowed 64-bit result. Optional SCL/SDA glitch filter: I2C_CALC_GLITCH_FILTER_EN.
module i2c_calc_target
  import i2c_calc_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR     = 7'h2A,
  parameter int          CALC_LATENCY = 2,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  i2c_calc_if.master  calc
);

  localparam int CW = $clog2(CALC_LATENCY + 1);

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  i2c_bus_cond #(.SYNC_STAGES(SYNC_STAGES)) u_cond (
    .clk, .rst_n, .scl_in, .sda_in,
    .scl_rise, .scl_fall, .sda_s, .start_det, .stop_det
  );

  i2c_state_e  state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shreg_q, shreg_d;
  logic [4:0]  ptr_q, ptr_d;
  logic        rw_q, rw_d;
  logic [7:0]  tx_q, tx_d;
  logic        sda_oe_q, sda_oe_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d;
  logic [1:0]  op_q, op_d;
  logic        go_q, go_d, busy_q, busy_d, valid_q, valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] shadow_q, shadow_d;

  logic [7:0]  byte_in, rd_cur, rd_nxt;
  logic        byte_done, ctrl_wr;

  function automatic logic [7:0] rd_mux(input logic [4:0] a, input logic [31:0] ra,
                                        input logic [31:0] rb, input logic [7:0] ctrl,
                                        input logic [7:0] stat, input logic [63:0] sh);
    logic [7:0] v;
    v = 8'h00;
    if (a[4:2] == REG_A0[4:2])        v = ra[{a[1:0], 3'b000} +: 8];
    else if (a[4:2] == REG_B0[4:2])   v = rb[{a[1:0], 3'b000} +: 8];
    else if (a == REG_CTRL)           v = ctrl;
    else if (a == REG_STATUS)         v = stat;
    else if (a[4:3] == REG_RES0[4:3]) v = sh[{a[2:0], 3'b000} +: 8];
    return v;
  endfunction

  assign rd_cur = rd_mux(ptr_q, opa_q, opb_q, {6'b0, op_q}, {6'b0, busy_q, valid_q}, shadow_q);
  assign rd_nxt = rd_mux(ptr_q + 5'd1, opa_q, opb_q, {6'b0, op_q}, {6'b0, busy_q, valid_q}, shadow_q);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    tx_d      = tx_q;
    sda_oe_d  = sda_oe_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    op_d      = op_q;
    ctrl_wr   = 1'b0;
    byte_done = 1'b0;
    byte_in   = {shreg_q, sda_s};

    if ((state_q == ADDR || state_q == PTR || state_q == WDATA) && scl_rise) begin
      shreg_d   = byte_in[6:0];
      bit_cnt_d = bit_cnt_q + 4'd1;
      if (bit_cnt_q == 4'd7) begin
        bit_cnt_d = '0;
        byte_done = 1'b1;
      end
    end

    case (state_q)
      ADDR: if (byte_done) begin
        if (byte_in[7:1] == I2C_ADDR) begin
          state_d = ADDR_ACK;
          rw_d    = byte_in[0];
          tx_d    = rd_cur;
        end else begin
          state_d = WAIT_STOP;
        end
      end
      PTR: if (byte_done) begin
        ptr_d   = byte_in[4:0];
        state_d = PTR_ACK;
      end
      WDATA: if (byte_done) begin
        ptr_d   = ptr_q + 5'd1;
        state_d = WDATA_ACK;
        if (ptr_q[4:2] == REG_A0[4:2])      opa_d[{ptr_q[1:0], 3'b000} +: 8] = byte_in;
        else if (ptr_q[4:2] == REG_B0[4:2]) opb_d[{ptr_q[1:0], 3'b000} +: 8] = byte_in;
        else if (ptr_q == REG_CTRL) begin
          op_d    = byte_in[1:0];
          ctrl_wr = 1'b1;
        end
      end
      // First SCL fall pulls SDA for the ACK bit, the second one hands the bus on
      ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
        if (!sda_oe_q) begin
          sda_oe_d = 1'b1;
        end else begin
          sda_oe_d  = 1'b0;
          bit_cnt_d = '0;
          if (state_q == ADDR_ACK && rw_q) begin
            state_d  = RDATA;
            sda_oe_d = ~tx_q[7];
          end else if (state_q == ADDR_ACK) begin
            state_d = PTR;
          end else begin
            state_d = WDATA;
          end
        end
      end
      RDATA: begin
        if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
        if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
            state_d  = RDATA_ACK;
          end else begin
            sda_oe_d = ~tx_q[~bit_cnt_q[2:0]];
          end
        end
      end
      RDATA_ACK: begin
        if (scl_rise) begin
          if (sda_s) begin
            state_d = WAIT_STOP;
          end else begin
            ptr_d = ptr_q + 5'd1;
            tx_d  = rd_nxt;
          end
        end
        if (scl_fall) begin
          state_d   = RDATA;
          bit_cnt_d = '0;
          sda_oe_d  = ~tx_q[7];
        end
      end
      default: ;
    endcase

    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end
  end

  // A CTRL write always reloads the counter, so the latest request wins
  always_comb begin
    go_d     = ctrl_wr;
    busy_d   = busy_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    if (ctrl_wr) begin
      busy_d  = 1'b1;
      valid_d = 1'b0;
      cnt_d   = CW'(CALC_LATENCY);
    end else if (busy_q) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        shadow_d = calc.result;
        valid_d  = 1'b1;
        busy_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      tx_q      <= '0;
      sda_oe_q  <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      op_q      <= '0;
      go_q      <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      shadow_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      tx_q      <= tx_d;
      sda_oe_q  <= sda_oe_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      op_q      <= op_d;
      go_q      <= go_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
    end
  end

  assign sda_oe         = sda_oe_q;
  assign calc.operand_a = opa_q;
  assign calc.operand_b = opb_q;
  assign calc.operation = op_q;
  assign calc.calc_go   = go_q;
  assign calc.busy      = busy_q;

endmodule

// File: tb/tb_i2c_calc_target.sv
// Bench for i2c_calc_target: bit-banged I2C controller, table of register
// write/readback vectors, read scoreboard and hand-written corner sequences.
module tb_i2c_calc_target;
  import i2c_calc_pkg::*;

  localparam int Q = 50;  // quarter SCL period; clk period is 10 -> 20 clk per SCL

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  logic sda_oe, sda_line;
  int   total = 0, bad = 0;
  int   go_hi = 0, go_pulses = 0, busy_hi = 0, oe_hi = 0;
  logic go_prev = 1'b0;
  logic [31:0] a_at_go = '0;
  logic [1:0]  op_at_go = '0;
  logic [7:0]  exp_q[$];

  i2c_calc_if cif ();

  assign sda_line   = sda_m & ~sda_oe;
  assign cif.result = 64'd112;

  i2c_calc_target dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .scl_in (scl_m),
    .sda_in (sda_line),
    .sda_oe (sda_oe),
    .calc   (cif)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cif.calc_go) begin
      go_hi++;
      a_at_go  = cif.operand_a;
      op_at_go = cif.operation;
    end
    if (cif.calc_go && !go_prev) go_pulses++;
    go_prev = cif.calc_go;
    if (cif.busy) busy_hi++;
    if (sda_oe) oe_hi++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #(2*Q);
  endtask

  task automatic write_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; #Q;
      scl_m = 1'b1; #(2*Q);
      scl_m = 1'b0; #Q;
    end
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string nm);
    logic got;
    write_bits(b, 8);
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    got = ~sda_line; #Q;
    scl_m = 1'b0; #Q;
    chk(nm, 64'(got), 64'(exp_ack));
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #Q; scl_m = 1'b1;
      #Q; b[i] = sda_line;
      #Q; scl_m = 1'b0;
      #Q;
    end
    sda_m = nack; #Q;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #Q;
    sda_m = 1'b1;
  endtask

  task automatic wr_reg(input logic [4:0] ptr, input logic [7:0] d);
    i2c_start();
    write_byte(8'h54, 1'b1, "wr_addr_ack");
    write_byte({3'b0, ptr}, 1'b1, "wr_ptr_ack");
    write_byte(d, 1'b1, "wr_data_ack");
    i2c_stop();
  endtask

  // Reads n bytes from ptr and checks each against the front of exp_q
  task automatic rd_reg(input logic [4:0] ptr, input int n, input string nm);
    logic [7:0] b, e;
    i2c_start();
    write_byte(8'h54, 1'b1, "rd_waddr_ack");
    write_byte({3'b0, ptr}, 1'b1, "rd_ptr_ack");
    i2c_start();
    write_byte(8'h55, 1'b1, "rd_raddr_ack");
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, b);
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL %s: byte %0d got %0h expected nothing queued", nm, i, b);
      end else begin
        e = exp_q.pop_front();
        chk(nm, 64'(b), 64'(e));
      end
    end
    i2c_stop();
  endtask

  typedef struct {
    logic [4:0] ptr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[7];
  logic [7:0] t1[9];
  int go0, pulse0, busy0, oe0;

  initial begin
    vt[0] = '{5'h00, 8'hA5, 8'hA5};
    vt[1] = '{5'h07, 8'h80, 8'h80};
    vt[2] = '{5'h0A, 8'h55, 8'h00};
    vt[3] = '{5'h10, 8'hAA, 8'h70};
    vt[4] = '{5'h1F, 8'h33, 8'h00};
    vt[5] = '{5'h08, 8'h01, 8'h01};
    vt[6] = '{5'h09, 8'hFF, 8'h01};
    t1 = '{8'h1C, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h02};

    #3 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_outputs", {sda_oe, cif.calc_go, cif.busy, cif.operation, cif.operand_a, cif.operand_b},
        '0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Operand load and calculation trigger
    go0 = go_hi; pulse0 = go_pulses; busy0 = busy_hi;
    i2c_start();
    write_byte(8'h54, 1'b1, "t1_addr_ack");
    write_byte(8'h00, 1'b1, "t1_ptr_ack");
    for (int i = 0; i < 9; i++) write_byte(t1[i], 1'b1, "t1_data_ack");
    i2c_stop();
    chk("t1_operand_a", 64'(cif.operand_a), 64'd28);
    chk("t1_operand_b", 64'(cif.operand_b), 64'd4);
    chk("t1_operation", 64'(cif.operation), 64'(OP_MUL));
    chk("t1_go_pulses", 64'(go_pulses - pulse0), 64'd1);
    chk("t1_go_width", 64'(go_hi - go0), 64'd1);
    chk("t1_busy_cycles", 64'(busy_hi - busy0), 64'd2);
    chk("t1_a_at_go", 64'(a_at_go), 64'd28);
    chk("t1_op_at_go", 64'(op_at_go), 64'(OP_MUL));

    // Result shadow readback and status
    exp_q.push_back(8'h70);
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h00);
    rd_reg(5'h10, 8, "t2_result");
    exp_q.push_back(8'h01);
    rd_reg(REG_STATUS, 1, "t2_status");

    for (int i = 0; i < 7; i++) begin
      wr_reg(vt[i].ptr, vt[i].wdata);
      exp_q.push_back(vt[i].exp);
      rd_reg(vt[i].ptr, 1, $sformatf("vec%0d_rd", i));
    end
    chk("vec_operand_a", 64'(cif.operand_a), 64'h0000_00A5);
    chk("vec_operand_b", 64'(cif.operand_b), 64'h8000_0004);
    chk("vec_operation", 64'(cif.operation), 64'(OP_SUB));

    // Foreign address: no ACK at all, no register change
    oe0 = oe_hi;
    i2c_start();
    write_byte(8'h56, 1'b0, "t3_addr_nack");
    write_byte(8'h00, 1'b0, "t3_ptr_nack");
    write_byte(8'hFF, 1'b0, "t3_data_nack");
    i2c_stop();
    chk("t3_sda_oe_idle", 64'(oe_hi - oe0), 64'd0);
    chk("t3_operand_a", 64'(cif.operand_a), 64'h0000_00A5);
    wr_reg(5'h04, 8'h09);
    chk("t3_follow_b", 64'(cif.operand_b), 64'h8000_0009);

    // Byte cut by STOP after 5 bits is discarded
    i2c_start();
    write_byte(8'h54, 1'b1, "t4_addr_ack");
    write_byte(8'h00, 1'b1, "t4_ptr_ack");
    write_bits(8'hFF, 5);
    i2c_stop();
    repeat (10) @(posedge clk);
    chk("t4_operand_a", 64'(cif.operand_a), 64'h0000_00A5);
    chk("t4_fsm_idle", 64'(dut.state_q), 64'(IDLE));

    // Pointer wrap 0x1F -> 0x00
    i2c_start();
    write_byte(8'h54, 1'b1, "t5_addr_ack");
    write_byte(8'h1F, 1'b1, "t5_ptr_ack");
    write_byte(8'h77, 1'b1, "t5_d0_ack");
    write_byte(8'h5A, 1'b1, "t5_d1_ack");
    i2c_stop();
    chk("t5_wrap_a", 64'(cif.operand_a), 64'h0000_005A);
    chk("t5_b_kept", 64'(cif.operand_b), 64'h8000_0009);

    // Reset asserted while the target drives the data-byte ACK
    i2c_start();
    write_byte(8'h54, 1'b1, "t6_addr_ack");
    write_byte(8'h04, 1'b1, "t6_ptr_ack");
    write_bits(8'hEE, 8);
    chk("t6_ack_driven", 64'(sda_oe), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_oe_async", 64'(sda_oe), 64'd0);
    chk("t6_outputs", {cif.calc_go, cif.busy, cif.operation, cif.operand_a, cif.operand_b}, '0);
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (10) @(posedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    wr_reg(5'h00, 8'h11);
    chk("t6_after_a", 64'(cif.operand_a), 64'h0000_0011);
    exp_q.push_back(8'h11);
    rd_reg(5'h00, 1, "t6_after_rd");
    chk("t6_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
